// File: rtl/fsm_010_event_logger_pkg.sv
// Shared types and defaults for the FSM_010 event logger.
// Event records pair a cycle timestamp with a users_count snapshot.
package fsm_010_event_logger_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_TS_W   = 16;
    localparam int DEF_CNT_W  = 10;
    localparam int DEF_DROP_W = 8;

    typedef struct packed {
        logic [DEF_TS_W-1:0]  ts;
        logic [DEF_CNT_W-1:0] cnt;
    } fsm_event_t;

endpackage

// File: rtl/fsm_event_fifo.sv
// Synchronous first-word-fall-through FIFO with a level counter.
// Full/empty come from the level so pointers can wrap freely.
module fsm_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 26
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    // A pop on a full FIFO frees the slot the push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign level = cnt;
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/fsm_010_event_logger.sv
// Captures FSM_010 detection pulses as timestamped records in a FIFO,
// with a saturating drop counter and sticky overflow flag.
module fsm_010_event_logger
    import fsm_010_event_logger_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int TS_W   = DEF_TS_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      y,
    input  logic [CNT_W-1:0]          users_count,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [TS_W-1:0]           ev_ts,
    output logic [CNT_W-1:0]          ev_count,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty,
    output logic [DROP_W-1:0]         dropped,
    output logic                      ovf,
    input  logic                      clr_ovf
);

    localparam int RW = TS_W + CNT_W;

    logic [TS_W-1:0] ts;
    logic [RW-1:0]   rec_in;
    logic [RW-1:0]   rec_head;
    logic            push_req;
    logic            drop;

    assign push_req = enable & y;
    assign rec_in   = {ts, users_count};

    // Full implies a head exists, so ev_ready alone decides whether a slot frees up.
    assign drop = push_req & full & ~ev_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts <= '0;
        else      ts <= ts + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dropped <= '0;
            ovf     <= 1'b0;
        end else if (drop) begin
            ovf     <= 1'b1;
            if (clr_ovf)             dropped <= DROP_W'(1);
            else if (dropped != '1)  dropped <= dropped + 1'b1;
        end else if (clr_ovf) begin
            ovf     <= 1'b0;
            dropped <= '0;
        end
    end

    fsm_event_fifo #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (ev_ready),
        .din   (rec_in),
        .dout  (rec_head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign ev_valid = ~empty;
    assign ev_ts    = empty ? '0 : rec_head[RW-1:CNT_W];
    assign ev_count = empty ? '0 : rec_head[CNT_W-1:0];

endmodule

// File: tb/tb_fsm_010_event_logger.sv
// Directed bench for the FSM_010 event logger: table vectors plus
// hand sequences for reset, wrap and detector-driven capture.
module tb_fsm_010_event_logger;

    localparam int DEPTH = 8;
    localparam int CNT_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b0;
    logic             enable = 1'b1;
    logic             y = 1'b0;
    logic [CNT_W-1:0] users_count = '0;
    logic             ev_ready = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             ev_valid;
    logic [15:0]      ev_ts;
    logic [CNT_W-1:0] ev_count;
    logic [3:0]       level;
    logic             full;
    logic             empty;
    logic [7:0]       dropped;
    logic             ovf;

    logic             y2 = 1'b0;
    logic [CNT_W-1:0] users2 = '0;
    logic             ready2 = 1'b0;
    logic             ev_valid2;
    logic [3:0]       ev_ts2;
    logic [CNT_W-1:0] ev_count2;
    logic [3:0]       level2;
    logic             full2;
    logic             empty2;
    logic [7:0]       dropped2;
    logic             ovf2;

    fsm_010_event_logger dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .y           (y),
        .users_count (users_count),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_ts       (ev_ts),
        .ev_count    (ev_count),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .dropped     (dropped),
        .ovf         (ovf),
        .clr_ovf     (clr_ovf)
    );

    fsm_010_event_logger #(.TS_W(4)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .enable      (1'b1),
        .y           (y2),
        .users_count (users2),
        .ev_valid    (ev_valid2),
        .ev_ready    (ready2),
        .ev_ts       (ev_ts2),
        .ev_count    (ev_count2),
        .level       (level2),
        .full        (full2),
        .empty       (empty2),
        .dropped     (dropped2),
        .ovf         (ovf2),
        .clr_ovf     (1'b0)
    );

    // Reference cycle counters restarted by the same reset as the DUTs.
    logic [15:0] mts;
    logic [3:0]  mts2;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mts  <= '0;
            mts2 <= '0;
        end else begin
            mts  <= mts + 1'b1;
            mts2 <= mts2 + 1'b1;
        end
    end

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic       y;
        logic       rdy;
        logic       clr;
        logic [9:0] users;
        int         lvl;
        logic       full;
        int         drp;
        logic       ovf;
        int         cnt;
    } vec_t;

    typedef struct {
        int ts;
        int cnt;
    } rec_t;

    vec_t tbl[13];
    rec_t q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] hist;
        logic [2:0] xseq;
        int         det;
        int         tsb;
        logic       pop_m;
        logic       acc_m;

        // Fill to overflow, push+pop while full, clr with and without a drop.
        tbl[0]  = '{1, 0, 0, 100, 1, 0, 0, 0, 100};
        tbl[1]  = '{1, 0, 0, 101, 2, 0, 0, 0, 100};
        tbl[2]  = '{1, 0, 0, 102, 3, 0, 0, 0, 100};
        tbl[3]  = '{1, 0, 0, 103, 4, 0, 0, 0, 100};
        tbl[4]  = '{1, 0, 0, 104, 5, 0, 0, 0, 100};
        tbl[5]  = '{1, 0, 0, 105, 6, 0, 0, 0, 100};
        tbl[6]  = '{1, 0, 0, 106, 7, 0, 0, 0, 100};
        tbl[7]  = '{1, 0, 0, 107, 8, 1, 0, 0, 100};
        tbl[8]  = '{1, 0, 0, 108, 8, 1, 1, 1, 100};
        tbl[9]  = '{1, 0, 0, 109, 8, 1, 2, 1, 100};
        tbl[10] = '{1, 1, 0, 200, 8, 1, 2, 1, 101};
        tbl[11] = '{1, 0, 1, 201, 8, 1, 1, 1, 101};
        tbl[12] = '{0, 0, 1, 0,   8, 1, 0, 0, 101};

        repeat (3) tick();
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_valid", ev_valid, 0);
        chk("rst_ts", ev_ts, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_ovf", ovf, 0);

        rst = 1'b1;
        repeat (5) tick();
        y = 1'b1;
        tick();
        y = 1'b0;
        chk("first_ts", ev_ts, 5);
        chk("first_valid", ev_valid, 1);
        y = 1'b1;
        users_count = 10'd1;
        repeat (2) tick();
        y = 1'b0;
        chk("three_level", level, 3);

        #2 rst = 1'b0;
        #1;
        chk("midrst_empty", empty, 1);
        chk("midrst_level", level, 0);
        chk("midrst_ts", ev_ts, 0);
        chk("midrst_count", ev_count, 0);
        chk("midrst_ovf", ovf, 0);
        tick();
        rst = 1'b1;

        for (int k = 0; k < 100 && mts != 16'd20; k++) tick();
        y = 1'b1;
        users_count = 10'd7;
        tick();
        y = 1'b0;
        chk("single_valid", ev_valid, 1);
        chk("single_ts", ev_ts, 20);
        chk("single_count", ev_count, 7);
        chk("single_level", level, 1);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        chk("single_empty", empty, 1);
        chk("single_ts_zero", ev_ts, 0);

        for (int i = 0; i < 13; i++) begin
            y           = tbl[i].y;
            ev_ready    = tbl[i].rdy;
            clr_ovf     = tbl[i].clr;
            users_count = tbl[i].users;
            tsb   = int'(mts);
            pop_m = tbl[i].rdy && q.size() > 0;
            acc_m = tbl[i].y && (q.size() < DEPTH || pop_m);
            tick();
            if (pop_m) void'(q.pop_front());
            if (acc_m) q.push_back('{tsb, int'(tbl[i].users)});
            chk($sformatf("v%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("v%0d_full", i), full, tbl[i].full);
            chk($sformatf("v%0d_dropped", i), dropped, tbl[i].drp);
            chk($sformatf("v%0d_ovf", i), ovf, tbl[i].ovf);
            chk($sformatf("v%0d_count", i), ev_count, tbl[i].cnt);
        end
        y = 1'b0;
        clr_ovf = 1'b0;

        ev_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (q.size() > 0) begin
                chk($sformatf("drain%0d_ts", k), ev_ts, q[0].ts);
                chk($sformatf("drain%0d_count", k), ev_count, q[0].cnt);
                void'(q.pop_front());
            end
            tick();
        end
        ev_ready = 1'b0;
        chk("drain_empty", empty, 1);

        enable = 1'b0;
        y = 1'b1;
        repeat (5) tick();
        y = 1'b0;
        enable = 1'b1;
        chk("dis_level", level, 0);
        chk("dis_dropped", dropped, 0);

        for (int k = 0; k < 40 && mts2 != 4'd15; k++) tick();
        y2 = 1'b1;
        users2 = 10'd0;
        tick();
        users2 = 10'd1;
        tick();
        y2 = 1'b0;
        chk("wrap_level", level2, 2);
        chk("wrap_ts0", ev_ts2, 15);
        chk("wrap_cnt0", ev_count2, 0);
        ready2 = 1'b1;
        tick();
        chk("wrap_ts1", ev_ts2, 0);
        chk("wrap_cnt1", ev_count2, 1);
        tick();
        ready2 = 1'b0;
        chk("wrap_empty", empty2, 1);

        // Stand-in for FSM_010: flag 010 on the x stream, count detections.
        hist = 3'b111;
        det = 0;
        xseq = 3'b010;
        for (int r = 0; r < 4; r++) begin
            for (int b = 2; b >= 0; b--) begin
                hist = {hist[1:0], xseq[b]};
                y = (hist == 3'b010);
                users_count = 10'(det);
                tick();
                if (hist == 3'b010) det++;
            end
        end
        y = 1'b0;
        chk("det_level", level, 4);
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("det%0d_count", k), ev_count, k);
            tick();
        end
        ev_ready = 1'b0;
        chk("det_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
